tessia_dmem_ctrl: RTL and testbench

//  Parametrised data-memory controller for the Tessia core; next generation of the plain data memory.

---
 rtl/tessia_mem_pkg.sv | 15 +
 rtl/tessia_byte_ram.sv | 31 +++
 rtl/tessia_dmem_ctrl.sv | 131 +++++++++++++
 tb/tb_tessia_dmem_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/tessia_mem_pkg.sv
// Shared types and constants for the Tessia data-memory controller.
// Holds the FSM state encoding, MMIO offsets and the RAM address-range check.
package tessia_mem_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} dmem_state_t;

    localparam int GPIO_OUT_OFS = 0;
    localparam int GPIO_IN_OFS  = 4;

    // Callers zero-extend to 64 bits so the same helper serves any ADDR_W.
    function automatic logic is_ram_addr(input logic [63:0] addr, input logic [63:0] ram_bytes);
        return addr < ram_bytes;
    endfunction

endpackage

// File: rtl/tessia_byte_ram.sv
// Byte-lane RAM: one 8-bit array per lane, synchronous write with a per-lane enable,
// registered read.
module tessia_byte_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [DATA_W/8-1:0]      be,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    localparam int BE_W = DATA_W / 8;

    for (genvar g = 0; g < BE_W; g++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_q;

        always_ff @(posedge clk) begin
            if (we && be[g])
                mem[waddr] <= wdata[g*8 +: 8];
            rd_q <= mem[raddr];
        end

        assign rdata[g*8 +: 8] = rd_q;
    end

endmodule

// File: rtl/tessia_dmem_ctrl.sv
// Data-memory controller: stalls the core while a RAM or GPIO access runs through
// IDLE -> BUSY (wait states) -> DONE, and flags misaligned or unmapped addresses.
module tessia_dmem_ctrl
    import tessia_mem_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH_WORDS = 1024,
    parameter int                WAIT_STATES = 0,
    parameter logic [ADDR_W-1:0] MMIO_BASE   = ADDR_W'(32'hFFFF_0000)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                MemRead,
    input  logic                MemWrite,
    input  logic [DATA_W/8-1:0] ByteEn,
    input  logic [ADDR_W-1:0]   Addr,
    input  logic [DATA_W-1:0]   WriteData,
    input  logic [DATA_W-1:0]   GpioIn,
    output logic [DATA_W-1:0]   ReadData,
    output logic                ReadValid,
    output logic                Stall,
    output logic                AddrFault,
    output logic [DATA_W-1:0]   GpioOut
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFS_W = $clog2(BE_W);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    dmem_state_t       state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [BE_W-1:0]   lat_be;
    logic              lat_store;
    logic [DATA_W-1:0] gpio_s1, gpio_s2;
    logic [DATA_W-1:0] ram_rdata;
    logic [IDX_W-1:0]  ram_raddr;

    logic misaligned, hit_ram, hit_gout, hit_gin, fault, commit, ram_we;

    assign misaligned = lat_addr[OFS_W-1:0] != '0;
    assign hit_ram    = is_ram_addr(64'(lat_addr), 64'(DEPTH_WORDS * BE_W));
    assign hit_gout   = lat_addr == MMIO_BASE + ADDR_W'(GPIO_OUT_OFS);
    assign hit_gin    = lat_addr == MMIO_BASE + ADDR_W'(GPIO_IN_OFS);
    assign fault      = misaligned | ~(hit_ram | hit_gout | hit_gin);

    assign commit = (state == BUSY) && (cnt == '0);
    assign ram_we = commit & lat_store & hit_ram & ~fault;
    assign Stall  = ((state == IDLE) & (MemRead | MemWrite)) | (state == BUSY);

    // Read from the live address while idle so registered RAM data is ready by commit,
    // even with zero wait states.
    assign ram_raddr = (state == IDLE) ? Addr[OFS_W +: IDX_W] : lat_addr[OFS_W +: IDX_W];

    tessia_byte_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH_WORDS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (lat_be),
        .waddr (lat_addr[OFS_W +: IDX_W]),
        .wdata (lat_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_s1 <= '0;
            gpio_s2 <= '0;
        end else begin
            gpio_s1 <= GpioIn;
            gpio_s2 <= gpio_s1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            lat_store <= 1'b0;
            ReadData  <= '0;
            ReadValid <= 1'b0;
            AddrFault <= 1'b0;
            GpioOut   <= '0;
        end else begin
            ReadValid <= 1'b0;
            AddrFault <= 1'b0;
            case (state)
                IDLE: begin
                    if (MemRead || MemWrite) begin
                        lat_addr  <= Addr;
                        lat_wdata <= WriteData;
                        lat_be    <= ByteEn;
                        lat_store <= MemWrite;
                        cnt       <= 4'(WAIT_STATES);
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state     <= DONE;
                        AddrFault <= fault;
                        ReadValid <= ~lat_store;
                        if (!lat_store) begin
                            if (fault)         ReadData <= '0;
                            else if (hit_ram)  ReadData <= ram_rdata;
                            else if (hit_gout) ReadData <= GpioOut;
                            else               ReadData <= gpio_s2;
                        end
                        if (lat_store && hit_gout && !fault) begin
                            for (int i = 0; i < BE_W; i++)
                                if (lat_be[i]) GpioOut[i*8 +: 8] <= lat_wdata[i*8 +: 8];
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tessia_dmem_ctrl.sv
// Bench for tessia_dmem_ctrl: two instances (0 and 3 wait states) driven by directed
// steps and random accesses, checked against a word-level memory/GPIO model.
module tb_tessia_dmem_ctrl;

    localparam logic [31:0] BASE  = 32'hFFFF_0000;
    localparam int          DEPTH = 64;
    localparam int          RAM_B = DEPTH * 4;

    logic        clk = 1'b0;
    logic        reset [2];
    logic        mr [2], mw [2];
    logic [3:0]  be [2];
    logic [31:0] addr [2], wd [2], gin [2];
    logic [31:0] rdata [2], gout [2];
    logic        rv [2], stall [2], af [2];

    logic [31:0] mem_m [2][DEPTH];
    bit          written [2][DEPTH];
    logic [31:0] gout_m [2];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    tessia_dmem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .MMIO_BASE(BASE)) u0 (
        .clk(clk), .reset(reset[0]), .MemRead(mr[0]), .MemWrite(mw[0]), .ByteEn(be[0]),
        .Addr(addr[0]), .WriteData(wd[0]), .GpioIn(gin[0]), .ReadData(rdata[0]),
        .ReadValid(rv[0]), .Stall(stall[0]), .AddrFault(af[0]), .GpioOut(gout[0]));

    tessia_dmem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(3), .MMIO_BASE(BASE)) u1 (
        .clk(clk), .reset(reset[1]), .MemRead(mr[1]), .MemWrite(mw[1]), .ByteEn(be[1]),
        .Addr(addr[1]), .WriteData(wd[1]), .GpioIn(gin[1]), .ReadData(rdata[1]),
        .ReadValid(rv[1]), .Stall(stall[1]), .AddrFault(af[1]), .GpioOut(gout[1]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete core access: model update, drive, count stall cycles, check DONE outputs.
    task automatic access(input int d, input bit rd, input bit wr, input logic [3:0] b,
                          input logic [31:0] a, input logic [31:0] w, input string tag);
        int ns;
        bit early, f, isram, isgo, isgi;
        logic [31:0] exp_d;
        int ws;
        ws    = (d == 0) ? 0 : 3;
        isram = a < RAM_B;
        isgo  = a == BASE;
        isgi  = a == BASE + 32'd4;
        f     = (a[1:0] != 2'b00) || !(isram || isgo || isgi);
        exp_d = '0;
        if (!wr && !f)
            exp_d = isram ? mem_m[d][a[7:2]] : (isgo ? gout_m[d] : gin[d]);
        if (wr && !f) begin
            for (int i = 0; i < 4; i++) begin
                if (b[i] && isram) mem_m[d][a[7:2]][i*8 +: 8] = w[i*8 +: 8];
                if (b[i] && isgo)  gout_m[d][i*8 +: 8] = w[i*8 +: 8];
            end
            if (isram && b == 4'hF) written[d][a[7:2]] = 1'b1;
        end
        @(posedge clk); #1;
        mr[d] = rd; mw[d] = wr; be[d] = b; addr[d] = a; wd[d] = w;
        ns = 0; early = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!stall[d]) break;
            ns++;
            if (rv[d] || af[d]) early = 1'b1;
        end
        check({tag, " stall_cycles"}, 32'(ns), 32'(ws + 2));
        check({tag, " early_pulse"}, {31'b0, early}, 32'd0);
        check({tag, " readvalid"}, {31'b0, rv[d]}, {31'b0, !wr});
        check({tag, " addrfault"}, {31'b0, af[d]}, {31'b0, f});
        if (!wr) check({tag, " readdata"}, rdata[d], exp_d);
        check({tag, " gpioout"}, gout[d], gout_m[d]);
        @(posedge clk); #1;
        mr[d] = 1'b0; mw[d] = 1'b0;
    endtask

    initial begin
        logic [31:0] a, w;
        logic [3:0]  b;
        int          idx, kind;
        bit          rd, wr;

        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b1; mr[d] = 1'b0; mw[d] = 1'b0; be[d] = '0;
            addr[d] = '0; wd[d] = '0; gin[d] = '0; gout_m[d] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                written[d][i] = 1'b0;
                mem_m[d][i] = '0;
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset stall", {31'b0, stall[d]}, 32'd0);
            check("reset readvalid", {31'b0, rv[d]}, 32'd0);
            check("reset addrfault", {31'b0, af[d]}, 32'd0);
            check("reset readdata", rdata[d], 32'd0);
            check("reset gpioout", gout[d], 32'd0);
        end
        @(posedge clk); #1;
        reset[0] = 1'b0; reset[1] = 1'b0;

        // Basic store/load, zero and three wait states
        access(0, 0, 1, 4'hF, 32'h10, 32'hDEAD_BEEF, "t1 store");
        access(0, 1, 0, 4'h0, 32'h10, 32'h0, "t1 load");
        access(1, 0, 1, 4'hF, 32'h20, 32'hCAFE_F00D, "t2 store");
        access(1, 1, 0, 4'h0, 32'h20, 32'h0, "t2 load");

        // Byte lanes, then both-op request treated as store
        access(0, 0, 1, 4'hF, 32'h30, 32'h1122_3344, "t3 full");
        access(0, 0, 1, 4'b0101, 32'h30, 32'hAAAA_AAAA, "t3 lanes");
        access(0, 1, 0, 4'h0, 32'h30, 32'h0, "t3 load");
        check("t3 model", mem_m[0][12], 32'h11AA_33AA);
        access(0, 1, 1, 4'h0, 32'h30, 32'hFFFF_FFFF, "t3 be0 both");
        access(0, 1, 0, 4'h0, 32'h30, 32'h0, "t3 reload");

        // MMIO window
        access(0, 0, 1, 4'hF, BASE, 32'h0000_00FF, "t4 gpo store");
        access(0, 1, 0, 4'h0, BASE, 32'h0, "t4 gpo load");
        gin[0] = 32'h5A;
        repeat (3) @(posedge clk);
        access(0, 1, 0, 4'h0, BASE + 32'd4, 32'h0, "t4 gpi load");
        access(0, 0, 1, 4'hF, BASE + 32'd4, 32'h1234, "t4 gpi store");

        // Faults
        access(0, 0, 1, 4'hF, 32'h0, 32'h1234_5678, "t5 word0");
        access(0, 1, 0, 4'h0, 32'h2, 32'h0, "t5 misaligned");
        access(0, 1, 0, 4'h0, RAM_B, 32'h0, "t5 unmapped ld");
        access(0, 0, 1, 4'hF, RAM_B, 32'hFFFF_FFFF, "t5 unmapped st");
        access(0, 1, 0, 4'h0, 32'h0, 32'h0, "t5 word0 load");

        // Reset in the middle of a three-wait-state store
        access(1, 0, 1, 4'hF, BASE, 32'h0000_ABCD, "t6 gpo");
        access(1, 0, 1, 4'hF, 32'h14, 32'h0000_0055, "t6 seed");
        @(posedge clk); #1;
        mr[1] = 1'b0; mw[1] = 1'b1; be[1] = 4'hF; addr[1] = 32'h14; wd[1] = 32'h99;
        repeat (2) @(posedge clk);
        #1;
        reset[1] = 1'b1; mw[1] = 1'b0;
        gout_m[1] = '0;
        @(negedge clk);
        check("t6 stall", {31'b0, stall[1]}, 32'd0);
        check("t6 gpioout", gout[1], 32'd0);
        @(posedge clk); #1;
        reset[1] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t6 no pulse", {30'b0, rv[1], af[1]}, 32'd0);
        end
        access(1, 1, 0, 4'h0, 32'h14, 32'h0, "t6 word load");

        // Random accesses against the model
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 30; n++) begin
                kind = $urandom_range(0, 9);
                idx  = $urandom_range(0, 15);
                w    = $urandom;
                b    = 4'($urandom);
                rd   = $urandom_range(0, 1) == 1;
                wr   = !rd;
                a    = 32'(idx * 4);
                if (kind <= 4 || kind == 9) begin
                    if (rd && !written[d][idx]) begin
                        rd = 1'b0; wr = 1'b1;
                    end
                    if (kind == 9) begin
                        rd = 1'b1; wr = 1'b1;
                    end
                    if (wr && !written[d][idx]) b = 4'hF;
                end else if (kind == 5) begin
                    a = BASE;
                end else if (kind == 6) begin
                    a = BASE + 32'd4;
                    if (rd) begin
                        gin[d] = $urandom;
                        repeat (3) @(posedge clk);
                    end
                end else if (kind == 7) begin
                    a = 32'(idx * 4 + $urandom_range(1, 3));
                end else begin
                    a = ($urandom_range(0, 1) == 1) ? 32'(RAM_B + idx * 4) : BASE + 32'd8;
                end
                access(d, rd, wr, b, a, w, "rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
